regfile_port_sched: RTL and testbench

Scheduler for one 512×64 register file. It shares the register file's single read port between two requesters (0 and 1) using round-robin arbitration. It passes a single write requester through to the write port. After reset it can optionally sweep every entry to zero before admitting any traffic. It sits between the pipeline stages and the register file; the register file's 1-cycle registered-address read latency is exposed unchanged to requesters.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_port_sched_if.sv | 34 +++
 rtl/regfile_port_sched_rr_arb2.sv | 28 ++
 rtl/regfile_port_sched.sv | 96 +++++++++
 tb/tb_regfile_port_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port scheduler: default geometry,
// scheduler state encoding and requester identifiers.
package regfile_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/regfile_port_sched_if.sv
// Requester-side bundle of the register-file scheduler: two read request
// channels, the shared read response and the write request channel.
interface regfile_port_sched_if
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          rq0_valid;
  logic [AW-1:0] rq0_addr;
  logic          rq0_ready;
  logic          rq1_valid;
  logic [AW-1:0] rq1_addr;
  logic          rq1_ready;
  logic          rs0_valid;
  logic          rs1_valid;
  logic [DW-1:0] rs_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  modport master (
    output rq0_valid, rq0_addr, rq1_valid, rq1_addr, wr_valid, wr_addr, wr_data,
    input  rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_data, wr_ready
  );

  modport slave (
    input  rq0_valid, rq0_addr, rq1_valid, rq1_addr, wr_valid, wr_addr, wr_data,
    output rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_data, wr_ready
  );

endinterface

// File: rtl/regfile_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted most
// recently wins. The last pointer only moves when a grant is actually issued.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    localparam logic ID = 1'(gi);
    assign gnt[gi] = req[gi] & (~req[1-gi] | (last_reg != ID));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_reg <= REQ1;
    end else if (advance && (|gnt)) begin
      last_reg <= gnt[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/regfile_port_sched.sv
// Read/write port scheduler for a 512x64 register file. Optional post-reset
// zero sweep is compiled in when REGFILE_CLEAR_EN is defined.
module regfile_port_sched
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_port_sched_if.slave   bus,
  output logic                  busy,
  output logic                  rf_rden,
  output logic [AW-1:0]         rf_rdaddress,
  input  logic [DW-1:0]         rf_q,
  output logic                  rf_wren,
  output logic [AW-1:0]         rf_wraddress,
  output logic [DW-1:0]         rf_data
);

  logic          in_run;
  logic [AW-1:0] clr_addr;

`ifdef REGFILE_CLEAR_EN
  state_t        state_reg;
  logic [AW-1:0] clr_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + AW'(1);
      if (&clr_cnt_reg) begin
        state_reg <= RUN;
      end
    end
  end

  assign in_run   = (state_reg == RUN);
  assign clr_addr = clr_cnt_reg;
  assign busy     = ~in_run;
`else
  assign in_run   = 1'b1;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  // No handshake completes while reset is asserted, so every ready reads 0.
  logic       admit;
  logic [1:0] req;
  logic [1:0] gnt;

  assign admit = in_run & ~reset;
  assign req   = {bus.rq1_valid, bus.rq0_valid} & {2{admit}};

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (admit),
    .gnt     (gnt)
  );

  logic [AW-1:0] rdaddr_reg;
  logic [1:0]    rs_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      rs_valid_reg <= '0;
      rdaddr_reg   <= '0;
    end else begin
      rs_valid_reg <= gnt;
      if (|gnt) begin
        rdaddr_reg <= rf_rdaddress;
      end
    end
  end

  // Holding the last granted address keeps rf_q stable between reads.
  assign rf_rden      = |gnt;
  assign rf_rdaddress = gnt[1] ? bus.rq1_addr :
                        gnt[0] ? bus.rq0_addr : rdaddr_reg;

  assign bus.rq0_ready = gnt[0];
  assign bus.rq1_ready = gnt[1];
  assign bus.rs0_valid = rs_valid_reg[0];
  assign bus.rs1_valid = rs_valid_reg[1];
  assign bus.rs_data   = rf_q;

  assign bus.wr_ready  = admit;
  assign rf_wren       = in_run ? (bus.wr_valid & admit) : 1'b1;
  assign rf_wraddress  = in_run ? bus.wr_addr : clr_addr;
  assign rf_data       = in_run ? bus.wr_data : '0;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural registered-address
// register file; covers the REGFILE_CLEAR_EN sweep when that macro is defined.
module tb_regfile_port_sched;

  localparam int AW = 9;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          busy;
  logic          rf_rden;
  logic [AW-1:0] rf_rdaddress;
  logic [DW-1:0] rf_q;
  logic          rf_wren;
  logic [AW-1:0] rf_wraddress;
  logic [DW-1:0] rf_data;

  int errors = 0;
  int checks = 0;

  regfile_port_sched_if #(.AW(AW), .DW(DW)) bus ();

  regfile_port_sched #(.AW(AW), .DW(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .rf_rden      (rf_rden),
    .rf_rdaddress (rf_rdaddress),
    .rf_q         (rf_q),
    .rf_wren      (rf_wren),
    .rf_wraddress (rf_wraddress),
    .rf_data      (rf_data)
  );

  always #5 clock = ~clock;

  // Register file: address latched on the same edge that commits a write.
  logic [DW-1:0] mem [0:511];
  logic [AW-1:0] rdaddr_q = '0;

  always @(posedge clock) begin
    if (rf_wren) mem[rf_wraddress] <= rf_data;
    if (rf_rden) rdaddr_q <= rf_rdaddress;
  end
  assign rf_q = mem[rdaddr_q];

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rq0_valid = 1'b1;
    bus.rq0_addr  = '0;
    repeat (3) tick;
    #1;
    checks++; if (bus.rq0_ready !== 1'b0) begin errors++; $display("FAIL rst_rq0_ready got=%0b exp=0", bus.rq0_ready); end
    checks++; if (bus.rq1_ready !== 1'b0) begin errors++; $display("FAIL rst_rq1_ready got=%0b exp=0", bus.rq1_ready); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%0b exp=0", bus.wr_ready); end
    checks++; if (bus.rs0_valid !== 1'b0) begin errors++; $display("FAIL rst_rs0_valid got=%0b exp=0", bus.rs0_valid); end
    checks++; if (bus.rs1_valid !== 1'b0) begin errors++; $display("FAIL rst_rs1_valid got=%0b exp=0", bus.rs1_valid); end
    checks++; if (rf_rden !== 1'b0) begin errors++; $display("FAIL rst_rf_rden got=%0b exp=0", rf_rden); end
`ifdef REGFILE_CLEAR_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%0b exp=1", busy); end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready got=%0b exp=1", bus.rq0_ready); end
    bus.rq0_valid = 1'b0;
`endif
    $display("reset: done");
  endtask

`ifdef REGFILE_CLEAR_EN
  task automatic test_clear;
    tick;
    reset = 1'b0;
    bus.rq0_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i != 0) tick;
      #1;
      checks++; if (rf_wren !== 1'b1) begin errors++; $display("FAIL clr_wren[%0d] got=%0b exp=1", i, rf_wren); end
      checks++; if (rf_wraddress !== i[8:0]) begin errors++; $display("FAIL clr_addr[%0d] got=%0d exp=%0d", i, rf_wraddress, i); end
      checks++; if (rf_data !== 64'h0) begin errors++; $display("FAIL clr_data[%0d] got=%h exp=0", i, rf_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d] got=%0b exp=1", i, busy); end
      checks++; if (bus.rq0_ready !== 1'b0) begin errors++; $display("FAIL clr_ready[%0d] got=%0b exp=0", i, bus.rq0_ready); end
    end
    tick;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_end_busy got=%0b exp=0", busy); end
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL clr_end_ready got=%0b exp=1", bus.rq0_ready); end
    checks++; if (rf_wren !== 1'b0) begin errors++; $display("FAIL clr_end_wren got=%0b exp=0", rf_wren); end
    bus.rq0_valid = 1'b0;
    $display("clear: sweep of 512 entries observed");
  endtask
`endif

  task automatic test_single_read;
    tick;
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd5; bus.wr_data = 64'hDEADBEEF_00000001;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL sr_wr_ready got=%0b exp=1", bus.wr_ready); end
    checks++; if (rf_wren !== 1'b1 || rf_wraddress !== 9'd5) begin errors++; $display("FAIL sr_wr_port got=%0b/%0d exp=1/5", rf_wren, rf_wraddress); end
    tick;
    bus.wr_valid = 1'b0;
    bus.rq0_valid = 1'b1; bus.rq0_addr = 9'd5;
    #1;
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL sr_ready got=%0b exp=1", bus.rq0_ready); end
    checks++; if (rf_rden !== 1'b1 || rf_rdaddress !== 9'd5) begin errors++; $display("FAIL sr_rd_port got=%0b/%0d exp=1/5", rf_rden, rf_rdaddress); end
    tick;
    bus.rq0_valid = 1'b0;
    #1;
    checks++; if (bus.rs0_valid !== 1'b1) begin errors++; $display("FAIL sr_rs0_valid got=%0b exp=1", bus.rs0_valid); end
    checks++; if (bus.rs1_valid !== 1'b0) begin errors++; $display("FAIL sr_rs1_valid got=%0b exp=0", bus.rs1_valid); end
    checks++; if (bus.rs_data !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL sr_data got=%h exp=deadbeef00000001", bus.rs_data); end
    $display("single_read: addr 5 -> %h", bus.rs_data);
  endtask

  task automatic test_same_cycle;
    tick;
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd7; bus.wr_data = 64'h11;
    tick;
    bus.wr_data = 64'h22;
    bus.rq1_valid = 1'b1; bus.rq1_addr = 9'd7;
    #1;
    checks++; if (bus.rq1_ready !== 1'b1) begin errors++; $display("FAIL sc_ready got=%0b exp=1", bus.rq1_ready); end
    tick;
    bus.wr_valid = 1'b0; bus.rq1_valid = 1'b0;
    #1;
    checks++; if (bus.rs1_valid !== 1'b1) begin errors++; $display("FAIL sc_rs1_valid got=%0b exp=1", bus.rs1_valid); end
    checks++; if (bus.rs0_valid !== 1'b0) begin errors++; $display("FAIL sc_rs0_valid got=%0b exp=0", bus.rs0_valid); end
    checks++; if (bus.rs_data !== 64'h22) begin errors++; $display("FAIL sc_data got=%h exp=22", bus.rs_data); end
    $display("same_cycle: addr 7 -> %h", bus.rs_data);
  endtask

  task automatic test_contention;
    logic [DW-1:0] exp_data [2];
    exp_data[0] = 64'h3333_3333_3333_3333;
    exp_data[1] = 64'h4444_4444_4444_4444;
    tick;
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd3; bus.wr_data = exp_data[0];
    tick;
    bus.wr_addr = 9'd4; bus.wr_data = exp_data[1];
    tick;
    bus.wr_valid = 1'b0;
    bus.rq0_valid = 1'b1; bus.rq0_addr = 9'd3;
    bus.rq1_valid = 1'b1; bus.rq1_addr = 9'd4;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) tick;
      if (k == 4) begin bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0; end
      #1;
      if (k < 4) begin
        checks++; if (bus.rq0_ready !== (k % 2 == 0)) begin errors++; $display("FAIL ct_ready0[%0d] got=%0b exp=%0b", k, bus.rq0_ready, (k % 2 == 0)); end
        checks++; if (bus.rq1_ready !== (k % 2 == 1)) begin errors++; $display("FAIL ct_ready1[%0d] got=%0b exp=%0b", k, bus.rq1_ready, (k % 2 == 1)); end
      end
      if (k > 0) begin
        checks++; if (bus.rs0_valid !== (k % 2 == 1)) begin errors++; $display("FAIL ct_rs0[%0d] got=%0b exp=%0b", k, bus.rs0_valid, (k % 2 == 1)); end
        checks++; if (bus.rs1_valid !== (k % 2 == 0)) begin errors++; $display("FAIL ct_rs1[%0d] got=%0b exp=%0b", k, bus.rs1_valid, (k % 2 == 0)); end
        checks++; if (bus.rs_data !== exp_data[(k - 1) % 2]) begin errors++; $display("FAIL ct_data[%0d] got=%h exp=%h", k, bus.rs_data, exp_data[(k - 1) % 2]); end
        $display("contention: response %0d data=%h", k - 1, bus.rs_data);
      end
    end
  endtask

  task automatic test_hold;
    tick;
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd9; bus.wr_data = 64'h99;
    tick;
    bus.wr_valid = 1'b0;
    bus.rq0_valid = 1'b1; bus.rq0_addr = 9'd9;
    #1;
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL hd_ready got=%0b exp=1", bus.rq0_ready); end
    tick;
    bus.rq0_valid = 1'b0; bus.rq0_addr = 9'd1; bus.rq1_addr = 9'd2;
    #1;
    checks++; if (bus.rs0_valid !== 1'b1 || bus.rs_data !== 64'h99) begin errors++; $display("FAIL hd_resp got=%0b/%h exp=1/99", bus.rs0_valid, bus.rs_data); end
    for (int j = 0; j < 3; j++) begin
      tick;
      #1;
      checks++; if (rf_rden !== 1'b0) begin errors++; $display("FAIL hd_rden[%0d] got=%0b exp=0", j, rf_rden); end
      checks++; if (rf_rdaddress !== 9'd9) begin errors++; $display("FAIL hd_addr[%0d] got=%0d exp=9", j, rf_rdaddress); end
      checks++; if (bus.rs0_valid !== 1'b0 || bus.rs1_valid !== 1'b0) begin errors++; $display("FAIL hd_strobe[%0d] got=%0b%0b exp=00", j, bus.rs1_valid, bus.rs0_valid); end
      checks++; if (bus.rs_data !== 64'h99) begin errors++; $display("FAIL hd_data[%0d] got=%h exp=99", j, bus.rs_data); end
    end
    $display("hold: addr 9 held for 3 idle cycles");
  endtask

  task automatic test_reset_mid;
    tick;
    bus.rq0_valid = 1'b1; bus.rq0_addr = 9'd5;
    #1;
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL rm_grant got=%0b exp=1", bus.rq0_ready); end
    tick;
    reset = 1'b1;
    #1;
    checks++; if (bus.rs0_valid !== 1'b1) begin errors++; $display("FAIL rm_pending got=%0b exp=1", bus.rs0_valid); end
    checks++; if (bus.rq0_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst got=%0b exp=0", bus.rq0_ready); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (bus.rs0_valid !== 1'b0 || bus.rs1_valid !== 1'b0) begin errors++; $display("FAIL rm_dropped got=%0b%0b exp=00", bus.rs1_valid, bus.rs0_valid); end
`ifdef REGFILE_CLEAR_EN
    checks++; if (rf_wren !== 1'b1 || rf_wraddress !== 9'd0) begin errors++; $display("FAIL rm_sweep got=%0b/%0d exp=1/0", rf_wren, rf_wraddress); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy got=%0b exp=1", busy); end
    checks++; if (bus.rq0_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got=%0b exp=0", bus.rq0_ready); end
`else
    checks++; if (bus.rq0_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%0b exp=1", bus.rq0_ready); end
`endif
    bus.rq0_valid = 1'b0;
    $display("reset_mid: pending strobe dropped");
  endtask

  initial begin
    reset = 1'b1;
    bus.rq0_valid = 1'b0; bus.rq0_addr = '0;
    bus.rq1_valid = 1'b0; bus.rq1_addr = '0;
    bus.wr_valid  = 1'b0; bus.wr_addr  = '0; bus.wr_data = '0;
    test_reset;
`ifdef REGFILE_CLEAR_EN
    test_clear;
`endif
    test_single_read;
    test_same_cycle;
    test_contention;
    test_hold;
    test_reset_mid;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
